// File: rtl/ov7670_stream_gen.sv
// Replays a stored frame as an OV7670-style vsync/href/byte stream, one pixel
// byte followed by PAD_BYTE per pixel, prefetching from a 1-cycle-latency framebuffer.
module ov7670_stream_gen #(
  parameter int          H_PIX    = 640,
  parameter int          H_BLANK  = 144,
  parameter int          V_SYNC   = 3,
  parameter int          V_BACK   = 17,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FRONT  = 10,
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int          ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_re,
  input  logic [7:0]        fb_rdata,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        dout,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int H_TOTAL = 2 * H_PIX + H_BLANK;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(2 * H_PIX);
  localparam logic [HW-1:0] H_LAST_ODD = HW'(2 * H_PIX - 1);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] PRE_LAST   = VW'(V_SYNC + V_BACK - 1);
  localparam logic [VW-1:0] ACT_LAST   = VW'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  typedef enum logic [2:0] {IDLE, VS, VB, ACT, VF} state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [VW-1:0]     vcnt_q, vcnt_d;
  logic              line_end;

  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic              sel_q, sel_d;
  logic [7:0]        dout_q, dout_d;
  logic              fb_re_q, fb_re_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  // State register: state_q/hcnt_q/vcnt_q describe the cycle currently on the outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign line_end = (hcnt_q == H_LAST);

  // Next-state logic; vcnt counts lines from the start of the frame.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (state_q == IDLE) begin
      if (en) begin
        state_d = VS;
        hcnt_d  = '0;
        vcnt_d  = '0;
      end
    end else if (line_end && vcnt_q == V_LAST) begin
      state_d = en ? VS : IDLE;
      hcnt_d  = '0;
      vcnt_d  = '0;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
      if (line_end) begin
        vcnt_d = vcnt_q + 1'b1;
        unique case (state_q)
          VS:      if (vcnt_q == VS_LAST)  state_d = (V_BACK == 0) ? ACT : VB;
          VB:      if (vcnt_q == PRE_LAST) state_d = ACT;
          ACT:     if (vcnt_q == ACT_LAST) state_d = VF;
          default: ;
        endcase
      end
    end
  end

  // Outputs are registered from the next-cycle state. fb_re looks one further
  // cycle ahead: it is set when the cycle after state_d carries an even active byte.
  always_comb begin
    vsync_d      = (state_d == VS);
    href_d       = (state_d == ACT) && (hcnt_d < H_ACT_END);
    sel_d        = href_d && !hcnt_d[0];
    dout_d       = href_d ? PAD_BYTE : 8'h00;
    frame_done_d = (state_d != IDLE) && (hcnt_d == H_LAST) && (vcnt_d == V_LAST);
    fb_re_d      = ((state_d == ACT) && hcnt_d[0] && (hcnt_d < H_LAST_ODD))
                || ((state_d == ACT) && (hcnt_d == H_LAST) && (vcnt_d < ACT_LAST))
                || (((state_d == VS) || (state_d == VB)) && (hcnt_d == H_LAST)
                    && (vcnt_d == PRE_LAST));
    addr_d       = addr_q;
    if ((state_d == VS) && (state_q != VS)) addr_d = '0;
    else if (fb_re_q)                       addr_d = addr_q + 1'b1;
    frame_cnt_d  = frame_cnt_q + {15'd0, frame_done_q};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      sel_q        <= 1'b0;
      dout_q       <= '0;
      fb_re_q      <= 1'b0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      sel_q        <= sel_d;
      dout_q       <= dout_d;
      fb_re_q      <= fb_re_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // The pixel byte comes straight from the framebuffer's output register, so
  // dout still only changes on pclk edges while honouring the 1-cycle prefetch.
  assign dout       = sel_q ? fb_rdata : dout_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign fb_re      = fb_re_q;
  assign fb_addr    = addr_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: frame-timeline model indexed by cycle-in-frame,
// plus literal expectations for the small test geometry.
module tb_ov7670_stream_gen;

  localparam int HP  = 4;
  localparam int HB  = 2;
  localparam int VSY = 1;
  localparam int VBK = 1;
  localparam int VAC = 2;
  localparam int VFR = 1;
  localparam int HT  = 2 * HP + HB;
  localparam int FT  = (VSY + VBK + VAC + VFR) * HT;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [18:0] fb_addr;
  logic        fb_re;
  logic [7:0]  fb_rdata = 8'h00;
  logic        vsync, href, frame_done;
  logic [7:0]  dout;
  logic [15:0] frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  ov7670_stream_gen #(
    .H_PIX(HP), .H_BLANK(HB), .V_SYNC(VSY), .V_BACK(VBK),
    .V_ACTIVE(VAC), .V_FRONT(VFR), .PAD_BYTE(8'h00), .ADDR_W(19)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en), .fb_addr(fb_addr), .fb_re(fb_re),
    .fb_rdata(fb_rdata), .vsync(vsync), .href(href), .dout(dout),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) if (fb_re) fb_rdata <= fb_addr[7:0] + 8'h10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: whether a frame is running, the cycle index within it, frames completed.
  bit m_run = 1'b0;
  int m_t = 0;
  int m_frames = 0;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_frames = 0;
    end else if (!m_run) begin
      if (en) begin m_run = 1'b1; m_t = 0; end
    end else if (m_t == FT - 1) begin
      m_frames++;
      if (en) m_t = 0; else m_run = 1'b0;
    end else begin
      m_t++;
    end
  end

  function automatic int act_line(input int t);
    return t / HT - VSY - VBK;
  endfunction
  function automatic bit in_href(input int t);
    return (t < FT) && act_line(t) >= 0 && act_line(t) < VAC && (t % HT) < 2 * HP;
  endfunction
  function automatic int pix(input int t);
    return act_line(t) * HP + (t % HT) / 2;
  endfunction

  // Scoreboard statistics collected since the last reset.
  int vs_cnt, vs_rise, rd_cnt, done_cnt, first_addr;
  logic vs_prev;
  logic [7:0] cap[$];

  always @(negedge pclk) begin
    if (rst_n) begin
      logic exp_href, exp_re;
      logic [7:0] exp_dout;
      exp_href = m_run && in_href(m_t);
      exp_dout = exp_href ? (((m_t % HT) % 2 == 0) ? 8'(pix(m_t) + 16) : 8'h00) : 8'h00;
      exp_re   = m_run && in_href(m_t + 1) && ((m_t + 1) % HT) % 2 == 0;
      chk("vsync", 32'(vsync), 32'(m_run && (m_t / HT) < VSY));
      chk("href", 32'(href), 32'(exp_href));
      chk("dout", 32'(dout), 32'(exp_dout));
      chk("fb_re", 32'(fb_re), 32'(exp_re));
      if (exp_re) chk("fb_addr", 32'(fb_addr), 32'(pix(m_t + 1)));
      chk("frame_done", 32'(frame_done), 32'(m_run && m_t == FT - 1));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
      chk("vs_href_excl", 32'(vsync && href), 32'd0);
      if (vsync) vs_cnt++;
      if (vsync && !vs_prev) vs_rise++;
      vs_prev = vsync;
      if (fb_re) begin
        if (rd_cnt == 0) first_addr = int'(fb_addr);
        rd_cnt++;
      end
      if (frame_done) done_cnt++;
      if (href) cap.push_back(dout);
    end
  end

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0; en = 1'b0;
    #2;
    vs_cnt = 0; vs_rise = 0; rd_cnt = 0; done_cnt = 0; first_addr = -1;
    vs_prev = 1'b0; cap.delete();
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 4 * FT * n && done_cnt < n; i++) @(negedge pclk);
    chk("done_timeout", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic wait_t(input int tt);
    for (int i = 0; i < 4 * FT && !(m_run && m_t == tt); i++) @(negedge pclk);
    chk("t_timeout", 32'(m_run && m_t == tt), 32'd1);
  endtask

  logic [7:0] exp_bytes [16];

  initial begin
    exp_bytes = '{8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00,
                  8'h14, 8'h00, 8'h15, 8'h00, 8'h16, 8'h00, 8'h17, 8'h00};
    rst_n = 1'b0; en = 1'b0;
    vs_cnt = 0; vs_rise = 0; rd_cnt = 0; done_cnt = 0; first_addr = -1; vs_prev = 1'b0;
    #12;
    chk("rst_vsync", 32'(vsync), 0); chk("rst_href", 32'(href), 0);
    chk("rst_dout", 32'(dout), 0);   chk("rst_fb_re", 32'(fb_re), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0); chk("rst_done", 32'(frame_done), 0);
    chk("rst_cnt", 32'(frame_cnt), 0);
    @(negedge pclk); rst_n = 1'b1;

    // Idle with en low.
    idle(100);
    chk("idle_vs", 32'(vs_cnt), 0); chk("idle_rd", 32'(rd_cnt), 0);
    chk("idle_bytes", 32'(cap.size()), 0);

    // Single frame from a one-cycle en pulse.
    do_reset();
    en = 1'b1; @(negedge pclk); en = 1'b0;
    wait_done(1); idle(20);
    chk("s_vs_cycles", 32'(vs_cnt), 10);
    chk("s_reads", 32'(rd_cnt), 8);
    chk("s_done", 32'(done_cnt), 1);
    chk("s_cnt", 32'(frame_cnt), 1);
    chk("s_nbytes", 32'(cap.size()), 16);
    for (int i = 0; i < 16 && i < cap.size(); i++) chk("s_byte", 32'(cap[i]), 32'(exp_bytes[i]));
    chk("s_idle_vs", 32'(vsync), 0);

    // Three back-to-back frames.
    do_reset();
    en = 1'b1;
    wait_done(2);
    @(negedge pclk); en = 1'b0;
    wait_done(3); idle(20);
    chk("b_cnt", 32'(frame_cnt), 3);
    chk("b_reads", 32'(rd_cnt), 24);
    chk("b_vs_rises", 32'(vs_rise), 3);
    chk("b_vs_cycles", 32'(vs_cnt), 30);

    // en dropped during active line 0.
    do_reset();
    en = 1'b1;
    wait_t((VSY + VBK) * HT + 2);
    en = 1'b0;
    wait_done(1); idle(20);
    chk("m_nbytes", 32'(cap.size()), 16);
    chk("m_cnt", 32'(frame_cnt), 1);
    chk("m_vs_rises", 32'(vs_rise), 1);

    // en high only on the last VF cycle restarts the stream.
    do_reset();
    en = 1'b1; @(negedge pclk); en = 1'b0;
    wait_t(FT - 1);
    en = 1'b1;
    @(negedge pclk); en = 1'b0;
    chk("l_vs_restart", 32'(vsync), 1);
    wait_done(2); idle(20);
    chk("l_cnt", 32'(frame_cnt), 2);

    // Asynchronous reset at hcnt=3 of active line 1.
    do_reset();
    en = 1'b1;
    wait_t((VSY + VBK + 1) * HT + 3);
    chk("a_pre_href", 32'(href), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("a_vsync", 32'(vsync), 0); chk("a_href", 32'(href), 0);
    chk("a_dout", 32'(dout), 0);   chk("a_fb_re", 32'(fb_re), 0);
    chk("a_fb_addr", 32'(fb_addr), 0); chk("a_cnt", 32'(frame_cnt), 0);
    rd_cnt = 0; done_cnt = 0; cap.delete(); first_addr = -1;
    @(negedge pclk); rst_n = 1'b1;
    idle(3); en = 1'b0;
    wait_done(1); idle(10);
    chk("a_first_addr", 32'(first_addr), 0);
    chk("a_reads", 32'(rd_cnt), 8);
    chk("a_first_byte", 32'(cap.size() > 0 ? cap[0] : 8'hff), 32'h10);
    chk("a_cnt_after", 32'(frame_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
- Transmit-side counterpart of the camera capture path: replays a stored frame as an OV7670-style parallel byte stream (vsync, href, 8-bit data), synchronous to pclk.
- Reads pixels from a framebuffer read port with a synchronous 1-cycle read latency.
- Drives capture/CNN pipelines in simulation and on-board loopback without a physical sensor.
- Each stored pixel byte is sent as a two-byte pair: pixel byte first, then PAD_BYTE.

Parameters:
- H_PIX, 640: active pixels per line; an active line is 2*H_PIX bytes.
- H_BLANK, 144: pclk cycles with href low after each line's active bytes.
- V_SYNC, 3: lines with vsync high at frame start.
- V_BACK, 17: blank lines after vsync, before the first active line.
- V_ACTIVE, 480: active lines per frame.
- V_FRONT, 10: blank lines after the last active line.
- PAD_BYTE, 8'h00: second byte of every pixel pair.
- ADDR_W, 19: framebuffer address width.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  frame enable; sampled only at frame boundaries.
- fb_addr  out  ADDR_W  framebuffer read address.
- fb_re  out  1  framebuffer read enable.
- fb_rdata  in  8  framebuffer read data; valid the cycle after fb_re.
- vsync  out  1  frame sync, active-high.
- href  out  1  line valid, active-high.
- dout  out  8  stream byte.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- frame_cnt  out  16  completed frames, wraps at 2^16.

Behaviour:
- Line timing:
  - H_TOTAL = 2*H_PIX + H_BLANK cycles.
  - hcnt runs 0..H_TOTAL-1 and wraps.
  - vcnt counts lines within the frame.
- Reset:
  - vsync=0, href=0, dout=0, fb_re=0, fb_addr=0, frame_done=0, frame_cnt=0.
  - State=IDLE; hcnt=0, vcnt=0.
- FSM states: IDLE, VS, VB, ACT, VF.
  - IDLE: all outputs low. Leaves when en=1: next cycle is the first VS cycle, with hcnt=0 and fb_addr=0.
  - VS: vsync=1 for exactly V_SYNC*H_TOTAL cycles, then VB.
  - VB: V_BACK*H_TOTAL cycles, then ACT. If V_BACK=0, VB is skipped.
  - ACT: V_ACTIVE lines.
    - href=1 for hcnt in [0, 2*H_PIX-1].
    - At even hcnt=2k, dout=fb_rdata of pixel k.
    - At odd hcnt, dout=PAD_BYTE.
    - href=0 and dout=0 during H_BLANK.
  - VF: V_FRONT*H_TOTAL cycles, then the frame-end decision.
- Frame-end decision, on the last VF cycle:
  - frame_done=1 for one cycle; frame_cnt increments.
  - If en=1, the next cycle is VS (back-to-back frames with no gap). Otherwise the next cycle is IDLE.
- en deasserted mid-frame: the current frame completes unchanged. en is ignored everywhere except IDLE and the last VF cycle.
- Read prefetch:
  - fb_re=1 and fb_addr=P exactly one cycle before the cycle where pixel P's byte appears on dout.
  - The first read of a frame is issued on the last cycle before ACT line 0.
  - fb_re=0 at all other times.
- Addressing:
  - Pixel index P = line*H_PIX + k; fb_addr increments by 1 per pixel.
  - Continuous across lines; no gaps at blanking.
  - Reloads to 0 at every frame start.
  - Width is truncated to ADDR_W with no saturation.
- Output registration:
  - vsync, href and dout are registered and change only on pclk rising edges.
  - href and dout change on the same edge.
  - vsync and href are never high simultaneously.
- Asynchronous reset mid-frame: all outputs drop to reset values immediately. After release, the block restarts from IDLE and waits for en.

Test Plan:
- Reset/idle: en=0, H_PIX=4, H_BLANK=2, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 -> all outputs stay 0 for 100 cycles.
- Single frame, same params, fb model returns addr+8'h10, en pulsed 1 cycle:
  - vsync high 10 cycles, then 10 blank cycles.
  - Each active line shows href high 8 cycles with dout = 10,00,11,00,12,00,13,00 on line 0 and 14,00,…,17,00 on line 1.
  - frame_done pulses once; frame_cnt=1; block returns to IDLE.
- Prefetch alignment: check fb_re/fb_addr=P one cycle before each even-hcnt byte; fb_re=0 during blanking; exactly 8 reads per frame.
- Back-to-back: en held high for 3 frames -> vsync rises on the cycle after each frame_done; frame_cnt=3; fb_addr restarts at 0 each frame.
- en dropped mid-ACT line 0 -> frame completes with all 16 active bytes, then IDLE. Separately, en=1 only on the last VF cycle -> next frame starts.
- Async reset asserted at hcnt=3 of active line 1 -> outputs 0 immediately; after release with en=1, a fresh frame starts with fb_addr=0.
